// File: rtl/hazard_scoreboard.sv
// Purpose: tracks EX/MEM/WB destination registers and raises a one-cycle load-use stall; optional stall counter under HAZARD_SCOREBOARD_STALL_CNT_EN.
// Latency: one cycle per stage (EX, MEM, WB all flopped); stall is combinational from decode inputs and EX state.
// Backpressure: stall holds fetch/decode and injects an EX bubble; flush overrides stall.
module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_wen,
  input  logic [4:0]       id_wnum,
  input  logic             id_is_load,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             flush,
  output logic             exe_wen,
  output logic [4:0]       exe_wnum,
  output logic             mem_wen,
  output logic [4:0]       mem_wnum,
  output logic             wb_wen,
  output logic [4:0]       wb_wnum,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic       ex_is_load;
  logic       bubble;
  logic       next_wen;
  logic [4:0] next_wnum;
  logic       next_is_load;
  logic       rs_hit;
  logic       rt_hit;

  // Only a load sitting in EX needs a stall; MEM/WB producers are forwarded.
  assign rs_hit = id_rs_used && (id_rs == exe_wnum);
  assign rt_hit = id_rt_used && (id_rt == exe_wnum);
  assign stall  = !rst && ex_is_load && exe_wen && !flush && (rs_hit || rt_hit);

  assign bubble = stall || flush || !id_valid;

  always_comb begin
    next_wen     = 1'b0;
    next_wnum    = 5'd0;
    next_is_load = 1'b0;
    if (!bubble) begin
      next_wen     = id_wen && (id_wnum != 5'd0);
      next_wnum    = id_wnum;
      next_is_load = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_wen    <= 1'b0;
      exe_wnum   <= 5'd0;
      ex_is_load <= 1'b0;
      mem_wen    <= 1'b0;
      mem_wnum   <= 5'd0;
      wb_wen     <= 1'b0;
      wb_wnum    <= 5'd0;
    end else begin
      exe_wen    <= next_wen;
      exe_wnum   <= next_wnum;
      ex_is_load <= next_is_load;
      mem_wen    <= exe_wen;
      mem_wnum   <= exe_wnum;
      wb_wen     <= mem_wen;
      wb_wnum    <= mem_wnum;
    end
  end

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with CNT_W=2; expectations depend on HAZARD_SCOREBOARD_STALL_CNT_EN.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_wen, id_is_load;
  logic [4:0] id_wnum, id_rs, id_rt;
  logic       id_rs_used, id_rt_used, flush;
  logic       exe_wen, mem_wen, wb_wen, stall;
  logic [4:0] exe_wnum, mem_wnum, wb_wnum;
  logic [1:0] stall_count;

  int checks   = 0;
  int failures = 0;

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_wen(id_wen), .id_wnum(id_wnum), .id_is_load(id_is_load),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .flush(flush),
    .exe_wen(exe_wen), .exe_wnum(exe_wnum),
    .mem_wen(mem_wen), .mem_wnum(mem_wnum),
    .wb_wen(wb_wen), .wb_wnum(wb_wnum),
    .stall(stall), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_wen = 0; id_wnum = 0; id_is_load = 0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; flush = 0;
  endtask

  task automatic drive_wr(input logic [4:0] wnum, input logic is_load);
    idle();
    id_valid = 1; id_wen = 1; id_wnum = wnum; id_is_load = is_load;
  endtask

  task automatic drive_use_rs(input logic [4:0] rs);
    idle();
    id_valid = 1; id_wen = 1; id_wnum = 5'd9; id_rs = rs; id_rs_used = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    check("rst_stall", stall, 0);
    rst = 0;
    #1;
    check("rst_exe_wen", exe_wen, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_wb_wen", wb_wen, 0);
    check("rst_wnums", {exe_wnum, mem_wnum, wb_wnum}, 0);
    check("rst_cnt", stall_count, 0);

    // ALU write r5 walks EX -> MEM -> WB
    drive_wr(5'd5, 0);
    tick();
    idle();
    check("alu_exe", {exe_wen, exe_wnum}, {1'b1, 5'd5});
    tick();
    check("alu_mem", {mem_wen, mem_wnum}, {1'b1, 5'd5});
    check("alu_exe_empty", exe_wen, 0);
    tick();
    check("alu_wb", {wb_wen, wb_wnum}, {1'b1, 5'd5});
    tick();
    check("alu_wb_gone", wb_wen, 0);

    // load-use: one stall cycle, then bubble in EX and load in MEM
    drive_wr(5'd8, 1);
    #1 check("lu_no_stall_before", stall, 0);
    tick();
    drive_use_rs(5'd8);
    #1 check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", exe_wen, 0);
    check("lu_mem", {mem_wen, mem_wnum}, {1'b1, 5'd8});
    check("lu_stall_once", stall, 0);
    check("lu_cnt", stall_count, CNT_EN ? 2'd1 : 2'd0);
    tick();
    check("lu_consumer_ex", {exe_wen, exe_wnum}, {1'b1, 5'd9});
    idle();

    // flush wins over stall
    drive_wr(5'd8, 1);
    tick();
    drive_use_rs(5'd8);
    flush = 1;
    #1 check("fl_stall", stall, 0);
    tick();
    idle();
    check("fl_bubble", {exe_wen, exe_wnum}, 0);

    // register 0 never written, never stalls
    drive_wr(5'd0, 0);
    tick();
    check("r0_wen", exe_wen, 0);
    drive_wr(5'd0, 1);
    tick();
    drive_use_rs(5'd0);
    id_rt_used = 1;
    #1 check("r0_stall", stall, 0);
    tick();
    idle();

    // load in MEM is forwarded, no stall
    drive_wr(5'd6, 1);
    tick();
    idle();
    tick();
    drive_use_rs(5'd6);
    #1 check("mem_fwd_stall", stall, 0);
    tick();
    idle();

    // reset during a stall discards the load
    drive_wr(5'd3, 1);
    tick();
    idle();
    id_valid = 1; id_rt = 5'd3; id_rt_used = 1;
    #1 check("rs_pre_stall", stall, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rs_wens", {exe_wen, mem_wen, wb_wen}, 0);
    check("rs_stall", stall, 0);
    check("rs_cnt", stall_count, 0);
    tick();
    idle();

    // five stalls: counter saturates at 3 when enabled
    for (int k = 1; k <= 5; k++) begin
      drive_wr(5'd4, 1);
      tick();
      drive_use_rs(5'd4);
      tick();
      idle();
      tick();
      check("sat_cnt", stall_count, CNT_EN ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
